// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the binary/Gray converter family.
//   GRAY_WIDTH_DEF : default code word width.
//   bin2gray(x)    : 32-bit binary-to-Gray reference conversion.
//   gray2bin(x)    : 32-bit Gray-to-binary reference conversion.
// Narrower users zero-extend to 32 bits, call the function and keep the low
// WIDTH bits. Leading zeros are a fixed point of both conversions, so the
// slice is exact for any width.
// ---------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_WIDTH_DEF = 4;
  localparam int GRAY_WIDTH_MAX = 32;

  function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(
    input logic [GRAY_WIDTH_MAX-1:0] x
  );
    return x ^ (x >> 1);
  endfunction

  // Prefix XOR from the MSB down: each binary bit is the parity of all Gray
  // bits at or above it.
  function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(
    input logic [GRAY_WIDTH_MAX-1:0] x
  );
    logic [GRAY_WIDTH_MAX-1:0] r;
    r[GRAY_WIDTH_MAX-1] = x[GRAY_WIDTH_MAX-1];
    for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ x[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bi_gray_conv_if.sv
// ---------------------------------------------------------------------------
// bi_gray_conv_if
// Word-stream bus for the binary/Gray converter.
//   in_valid  : input word qualifier
//   dir       : 0 = binary->Gray, 1 = Gray->binary
//   b         : input word
//   g         : registered converted word
//   out_valid : one-cycle strobe per converted word
// master drives the request side (in_valid/dir/b), slave drives the result.
// ---------------------------------------------------------------------------
interface bi_gray_conv_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
);

  logic             in_valid;
  logic             dir;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] g;
  logic             out_valid;

  modport master (
    output in_valid,
    output dir,
    output b,
    input  g,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  dir,
    input  b,
    output g,
    output out_valid
  );

endinterface

// File: rtl/gray_xor_core.sv
// ---------------------------------------------------------------------------
// gray_xor_core
// Combinational conversion network: both XOR networks plus a direction mux.
//   dir  in  1     : 0 = binary->Gray, 1 = Gray->binary
//   din  in  WIDTH : input word
//   dout out WIDTH : converted word
// ---------------------------------------------------------------------------
module gray_xor_core
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] b2g;
  logic [WIDTH-1:0] g2b;

  // The package functions are 32 bits wide; zero-extend in, truncate out.
  assign b2g  = WIDTH'(bin2gray(GRAY_WIDTH_MAX'(din)));
  assign g2b  = WIDTH'(gray2bin(GRAY_WIDTH_MAX'(din)));
  assign dout = dir ? g2b : b2g;

endmodule

// File: rtl/bi_gray_conv.sv
// ---------------------------------------------------------------------------
// bi_gray_conv
// Registered, width-parameterized binary/Gray converter, latency 1, one word
// per cycle, no backpressure.
//   clk   in : clock, rising edge
//   rst_n in : asynchronous active-low reset; clears g and out_valid
//   bus      : bi_gray_conv_if slave (in_valid, dir, b -> g, out_valid)
// g holds its last value on cycles without in_valid; out_valid follows
// in_valid one cycle later.
// ---------------------------------------------------------------------------
module bi_gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  bi_gray_conv_if.slave       bus
);

  logic [WIDTH-1:0] conv_p0;
  logic [WIDTH-1:0] g_p1;
  logic             vld_p1;

  gray_xor_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .dir  (bus.dir),
    .din  (bus.b),
    .dout (conv_p0)
  );

  // p0 -> p1: output register, loaded only on accepted words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        g_p1 <= conv_p0;
      end
    end
  end

  assign bus.g         = g_p1;
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_bi_gray_conv.sv
// ---------------------------------------------------------------------------
// tb_bi_gray_conv
// Self-checking bench for bi_gray_conv (WIDTH=4 and WIDTH=8 instances).
// Expected words are queued when a word is driven and popped when the DUT
// presents its result one cycle later.
// ---------------------------------------------------------------------------
module tb_bi_gray_conv;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bi_gray_conv_if #(.WIDTH(4)) bus4 ();
  bi_gray_conv_if #(.WIDTH(8)) bus8 ();

  bi_gray_conv #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  bi_gray_conv #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] sb4[$];
  logic [3:0] held4 = '0;

  logic [3:0] sweep_tbl [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  // Independent bitwise binary->Gray model for the round-trip stimulus.
  function automatic logic [3:0] model_b2g(input logic [3:0] x);
    logic [3:0] r;
    r[3] = x[3];
    for (int i = 0; i < 3; i++) r[i] = x[i+1] ^ x[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the WIDTH=4 stream: drive at the falling edge, let the
  // rising edge sample, check at the next falling edge.
  task automatic step4(input logic v, input logic d, input logic [3:0] x,
                       input logic [3:0] exp, input string tag);
    bus4.in_valid = v;
    bus4.dir      = d;
    bus4.b        = x;
    if (v) sb4.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld"}, 8'(bus4.out_valid), 8'(v));
    if (v) begin
      if (sb4.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL %s_sb: observed empty queue expected entry", tag);
      end else begin
        held4 = sb4.pop_front();
      end
    end
    check(tag, 8'(bus4.g), 8'(held4));
  endtask

  task automatic step8(input logic d, input logic [7:0] x, input logic [7:0] exp,
                       input string tag);
    bus8.in_valid = 1'b1;
    bus8.dir      = d;
    bus8.b        = x;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check({tag, "_vld"}, 8'(bus8.out_valid), 8'h01);
    check(tag, bus8.g, exp);
  endtask

  initial begin
    bus4.in_valid = 1'b0;
    bus4.dir      = 1'b0;
    bus4.b        = '0;
    bus8.in_valid = 1'b0;
    bus8.dir      = 1'b0;
    bus8.b        = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_g4", 8'(bus4.g), 8'h00);
    check("rst_vld4", 8'(bus4.out_valid), 8'h00);
    check("rst_g8", bus8.g, 8'h00);
    check("rst_vld8", 8'(bus8.out_valid), 8'h00);
    rst_n = 1'b1;

    // Binary->Gray sweep, back to back
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, 1'b0, 4'(i), sweep_tbl[i], $sformatf("b2g_%0d", i));
    end

    // Gray->binary directed
    step4(1'b1, 1'b1, 4'b1000, 4'b1111, "g2b_1000");
    step4(1'b1, 1'b1, 4'b1010, 4'b1100, "g2b_1010");
    step4(1'b1, 1'b1, 4'b0110, 4'b0100, "g2b_0110");

    // Round trip: Gray of x fed back must return x
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, 1'b1, model_b2g(4'(i)), 4'(i), $sformatf("rt_%0d", i));
    end

    // Valid gating: one word then three idle cycles with a different b
    step4(1'b1, 1'b0, 4'b0101, 4'b0111, "gate_w");
    for (int i = 0; i < 3; i++) begin
      step4(1'b0, 1'b0, 4'b1111, 4'b0000, $sformatf("gate_idle_%0d", i));
    end

    // Alternating direction on a constant word
    step4(1'b1, 1'b0, 4'b1111, 4'b1000, "alt_0");
    step4(1'b1, 1'b1, 4'b1111, 4'b1010, "alt_1");
    step4(1'b1, 1'b0, 4'b1111, 4'b1000, "alt_2");

    // Asynchronous reset between edges while g = 1000
    bus4.in_valid = 1'b1;
    bus4.b        = 4'b0101;
    bus4.dir      = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_g", 8'(bus4.g), 8'h00);
    check("arst_vld", 8'(bus4.out_valid), 8'h00);
    // Word presented across an edge during reset is discarded
    @(posedge clk);
    @(negedge clk);
    check("arst_hold_g", 8'(bus4.g), 8'h00);
    check("arst_hold_vld", 8'(bus4.out_valid), 8'h00);
    sb4.delete();
    held4 = '0;
    rst_n = 1'b1;
    step4(1'b1, 1'b0, 4'b0011, 4'b0010, "post_rst");
    step4(1'b0, 1'b0, 4'b0000, 4'b0000, "post_rst_idle");

    // WIDTH=8 instance
    step8(1'b0, 8'hFF, 8'h80, "w8_ff");
    step8(1'b0, 8'hA5, 8'hF7, "w8_a5");
    step8(1'b1, 8'h80, 8'hFF, "w8_g2b_80");

    check("sb_drained", 8'(sb4.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
